// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, result select and load formatting, with x0/fault write suppression.
// Optional WB_INSTRET_EN builds a 64-bit retired-instruction counter; without it instretCount is tied to 0.
module writeback_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memRd,
  input  logic [1:0]        memResultSel,
  input  logic [XLEN-1:0]   memAluResult,
  input  logic [XLEN-1:0]   memLoadData,
  input  logic [2:0]        memLoadFunct3,
  input  logic [XLEN-1:0]   memPcPlus4,
  input  logic [XLEN-1:0]   memImm,
  output logic              writeEnable,
  output logic [REG_AW-1:0] writeAddress,
  output logic [XLEN-1:0]   writeData,
  output logic              wbValid,
  output logic              wbLoadFault,
  output logic [63:0]       instretCount
);

  logic [1:0]        w_off;
  logic [XLEN-1:0]   w_byte_sh;
  logic [XLEN-1:0]   w_half_sh;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load;
  logic              w_fmt_fault;
  logic              w_fault;
  logic [XLEN-1:0]   w_result;

  logic              r_valid;
  logic              r_regwrite;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;
  logic              r_fault;

  assign w_off     = memAluResult[1:0];
  assign w_byte_sh = memLoadData >> {w_off, 3'b000};
  assign w_half_sh = memLoadData >> {w_off[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  always_comb begin
    w_load      = '0;
    w_fmt_fault = 1'b0;
    case (memLoadFunct3)
      3'b000: w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001: begin
        w_load      = {{(XLEN-16){w_half[15]}}, w_half};
        w_fmt_fault = w_off[0];
      end
      3'b010: begin
        w_load      = memLoadData;
        w_fmt_fault = (w_off != 2'b00);
      end
      3'b100: w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101: begin
        w_load      = {{(XLEN-16){1'b0}}, w_half};
        w_fmt_fault = w_off[0];
      end
      default: w_fmt_fault = 1'b1;
    endcase

    // Format faults only matter for a real instruction that selects load data.
    w_fault = memValid && (memResultSel == 2'b01) && w_fmt_fault;

    case (memResultSel)
      2'b00:   w_result = memAluResult;
      2'b01:   w_result = w_load;
      2'b10:   w_result = memPcPlus4;
      default: w_result = memImm;
    endcase
    if (w_fault) w_result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_fault    <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_fault    <= 1'b0;
    end else if (!stall) begin
      r_valid    <= memValid;
      r_regwrite <= memRegWrite;
      r_rd       <= memRd;
      r_data     <= w_result;
      r_fault    <= w_fault;
    end
  end

  assign wbValid      = r_valid;
  assign wbLoadFault  = r_fault;
  assign writeAddress = r_rd;
  assign writeData    = r_data;
  assign writeEnable  = r_valid & r_regwrite & (r_rd != '0) & ~r_fault;

`ifdef WB_INSTRET_EN
  logic        r_retired;
  logic [63:0] r_instret;
  logic        w_retire;

  // The WB occupant retires on its first edge in WB; r_retired blocks recounting under stall.
  assign w_retire = r_valid & ~r_fault & ~r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 64'd1;
      if (flush || !stall) r_retired <= 1'b0;
      else if (w_retire)   r_retired <= 1'b1;
    end
  end

  assign instretCount = r_instret;
`else
  assign instretCount = '0;
`endif

endmodule
